// File: rtl/vga_timing_gen_if.sv
// VGA timing bundle: run/freeze control in, pixel strobe, position,
// sync levels and line/frame markers out.
interface vga_timing_gen_if #(
  parameter int CNT_W   = 10,
  parameter int FRAME_W = 16
);
  logic               enable;
  logic               p_tick;
  logic [CNT_W-1:0]   x;
  logic [CNT_W-1:0]   y;
  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    input  enable,
    output p_tick, x, y, hsync, vsync, video_on,
    output line_start, frame_start, frame_cnt
  );

  modport slave (
    output enable,
    input  p_tick, x, y, hsync, vsync, video_on,
    input  line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator; the frame counter is built only when
// VGA_TIMING_FRAME_CNT_EN is defined, otherwise frame_cnt is tied to 0.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 10,
  parameter int FRAME_W   = 16
) (
  input logic clk,
  input logic reset,
  vga_timing_gen_if.master vga
);

  localparam int HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  generate
    if (CLK_DIV < 1 ||
        H_DISPLAY < 1 || H_FRONT < 1 ||
        H_SYNC < 1 || H_BACK < 1 ||
        V_DISPLAY < 1 || V_FRONT < 1 ||
        V_SYNC < 1 || V_BACK < 1 ||
        HT > (2 ** CNT_W) ||
        VT > (2 ** CNT_W)) begin : g_bad_cfg
      $error("vga_timing_gen: unsupported parameter set");
    end
  endgenerate

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_q, video_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
  logic             p_tick;
  logic             x_wrap;

  assign p_tick = vga.enable &&
                  (div_q == DIV_W'(CLK_DIV - 1));
  assign x_wrap = (x_q == CNT_W'(HT - 1));

  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    if (vga.enable) begin
      div_d = p_tick ? '0 : div_q + 1'b1;
    end
    if (p_tick) begin
      x_d = x_wrap ? '0 : x_q + 1'b1;
      if (x_wrap) begin
        y_d = (y_q == CNT_W'(VT - 1)) ? '0 : y_q + 1'b1;
      end
    end
  end

  // Status decodes use next-state x/y so they line up with x/y.
  always_comb begin
    hsync_d = ~HSYNC_POL;
    vsync_d = ~VSYNC_POL;
    if (x_d >= CNT_W'(HS_START) && x_d <= CNT_W'(HS_END)) begin
      hsync_d = HSYNC_POL;
    end
    if (y_d >= CNT_W'(VS_START) && y_d <= CNT_W'(VS_END)) begin
      vsync_d = VSYNC_POL;
    end
    video_d = (x_d < CNT_W'(H_DISPLAY)) &&
              (y_d < CNT_W'(V_DISPLAY));
    line_d  = p_tick && (x_d == '0);
    frame_d = line_d && (y_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      video_q <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (frame_d) begin
      fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign vga.frame_cnt = fcnt_q;
`else
  assign vga.frame_cnt = '0;
`endif

  assign vga.p_tick      = p_tick;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_q;
  assign vga.line_start  = line_q;
  assign vga.frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a tiny raster for frame-level checks and the
// default 640x480 raster for line, freeze and reset checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;

  always #5 clk = ~clk;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam int FC_ON = 1;
`else
  localparam int FC_ON = 0;
`endif

  vga_timing_gen_if #(.CNT_W(10), .FRAME_W(16)) b0 ();
  vga_timing_gen_if #(.CNT_W(10), .FRAME_W(2))  b1 ();

  vga_timing_gen u0 (
    .clk   (clk),
    .reset (rst0),
    .vga   (b0)
  );

  vga_timing_gen #(
    .H_DISPLAY (4),
    .H_FRONT   (1),
    .H_SYNC    (2),
    .H_BACK    (1),
    .V_DISPLAY (3),
    .V_FRONT   (1),
    .V_SYNC    (1),
    .V_BACK    (1),
    .CLK_DIV   (1),
    .HSYNC_POL (1'b1),
    .FRAME_W   (2)
  ) u1 (
    .clk   (clk),
    .reset (rst1),
    .vga   (b1)
  );

  typedef struct {
    int k;
    int x;
    int y;
    int hs;
    int vs;
    int vo;
    int ls;
    int fs;
    int fc;
  } vec_t;

  vec_t tbl[14];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int ti;
    // k = clk edges after release: x = k%8, y = (k/8)%6
    tbl[0]  = '{1,  1, 0, 0, 1, 1, 0, 0, 0};
    tbl[1]  = '{4,  4, 0, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{5,  5, 0, 1, 1, 0, 0, 0, 0};
    tbl[3]  = '{6,  6, 0, 1, 1, 0, 0, 0, 0};
    tbl[4]  = '{7,  7, 0, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{8,  0, 1, 0, 1, 1, 1, 0, 0};
    tbl[6]  = '{9,  1, 1, 0, 1, 1, 0, 0, 0};
    tbl[7]  = '{27, 3, 3, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{32, 0, 4, 0, 0, 0, 1, 0, 0};
    tbl[9]  = '{39, 7, 4, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{40, 0, 5, 0, 1, 0, 1, 0, 0};
    tbl[11] = '{47, 7, 5, 0, 1, 0, 0, 0, 0};
    tbl[12] = '{48, 0, 0, 0, 1, 1, 1, 1, 1};
    tbl[13] = '{49, 1, 0, 0, 1, 1, 0, 0, 1};

    rst0 = 1'b1;
    rst1 = 1'b1;
    b0.enable = 1'b1;
    b1.enable = 1'b1;
    #2;

    chk("rst x", b0.x, 0);
    chk("rst y", b0.y, 0);
    chk("rst hsync", b0.hsync, 1);
    chk("rst vsync", b0.vsync, 1);
    chk("rst video_on", b0.video_on, 0);
    chk("rst line_start", b0.line_start, 0);
    chk("rst frame_start", b0.frame_start, 0);
    chk("rst frame_cnt", b0.frame_cnt, 0);
    chk("rst p_tick", b0.p_tick, 0);
    chk("rst small hsync", b1.hsync, 0);

    tick(1);
    rst1 = 1'b0;
    ti = 0;
    for (int k = 1; k <= 49; k++) begin
      tick(1);
      if (ti < 14 && tbl[ti].k == k) begin
        chk($sformatf("k%0d x", k), b1.x, tbl[ti].x);
        chk($sformatf("k%0d y", k), b1.y, tbl[ti].y);
        chk($sformatf("k%0d hsync", k), b1.hsync, tbl[ti].hs);
        chk($sformatf("k%0d vsync", k), b1.vsync, tbl[ti].vs);
        chk($sformatf("k%0d video_on", k), b1.video_on, tbl[ti].vo);
        chk($sformatf("k%0d line_start", k), b1.line_start, tbl[ti].ls);
        chk($sformatf("k%0d frame_start", k), b1.frame_start, tbl[ti].fs);
        chk($sformatf("k%0d frame_cnt", k), b1.frame_cnt,
            FC_ON != 0 ? tbl[ti].fc : 0);
        chk($sformatf("k%0d p_tick", k), b1.p_tick, 1);
        ti++;
      end
    end

    for (int f = 2; f <= 5; f++) begin
      tick(f == 2 ? 47 : 48);
      chk($sformatf("frame%0d frame_start", f), b1.frame_start, 1);
      chk($sformatf("frame%0d frame_cnt", f), b1.frame_cnt,
          FC_ON != 0 ? f % 4 : 0);
    end

    tick(32);
    chk("small mid vsync", b1.vsync, 0);
    chk("small mid y", b1.y, 4);
    rst1 = 1'b1;
    #1;
    chk("small rst vsync", b1.vsync, 1);
    chk("small rst x", b1.x, 0);
    chk("small rst y", b1.y, 0);
    chk("small rst frame_cnt", b1.frame_cnt, 0);

    rst0 = 1'b0;
    tick(1);
    chk("rel video_on", b0.video_on, 1);
    chk("rel frame_start", b0.frame_start, 0);
    chk("rel line_start", b0.line_start, 0);
    chk("rel x", b0.x, 0);
    chk("rel p_tick", b0.p_tick, 1);
    tick(1);
    chk("e2 x", b0.x, 1);
    chk("e2 p_tick", b0.p_tick, 0);
    tick(1276);
    chk("x639 video_on", b0.video_on, 1);
    tick(2);
    chk("x640 x", b0.x, 640);
    chk("x640 video_on", b0.video_on, 0);
    tick(30);
    chk("x655 hsync", b0.hsync, 1);
    tick(2);
    chk("x656 hsync", b0.hsync, 0);
    tick(190);
    chk("x751 hsync", b0.hsync, 0);
    tick(2);
    chk("x752 hsync", b0.hsync, 1);
    tick(96);
    chk("line1 x", b0.x, 0);
    chk("line1 y", b0.y, 1);
    chk("line1 line_start", b0.line_start, 1);
    chk("line1 frame_start", b0.frame_start, 0);
    tick(1);
    chk("line1+1 line_start", b0.line_start, 0);
    tick(1599);
    chk("line2 line_start", b0.line_start, 1);
    chk("line2 y", b0.y, 2);

    tick(8200);
    chk("pre-freeze x", b0.x, 100);
    chk("pre-freeze y", b0.y, 7);
    b0.enable = 1'b0;
    tick(50);
    chk("freeze x", b0.x, 100);
    chk("freeze y", b0.y, 7);
    chk("freeze p_tick", b0.p_tick, 0);
    chk("freeze line_start", b0.line_start, 0);
    chk("freeze video_on", b0.video_on, 1);
    b0.enable = 1'b1;
    tick(1);
    chk("resume1 x", b0.x, 100);
    chk("resume1 p_tick", b0.p_tick, 1);
    tick(1);
    chk("resume2 x", b0.x, 101);

    tick(1198);
    chk("x700 x", b0.x, 700);
    chk("x700 hsync", b0.hsync, 0);
    rst0 = 1'b1;
    #1;
    chk("midrst x", b0.x, 0);
    chk("midrst y", b0.y, 0);
    chk("midrst hsync", b0.hsync, 1);
    chk("midrst vsync", b0.vsync, 1);
    chk("midrst video_on", b0.video_on, 0);
    tick(2);
    rst0 = 1'b0;
    tick(1);
    chk("rel2 video_on", b0.video_on, 1);
    chk("rel2 frame_start", b0.frame_start, 0);
    chk("rel2 line_start", b0.line_start, 0);
    chk("rel2 hsync", b0.hsync, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch
- CLK_DIV, 2, clk cycles per pixel, at least 1
- HSYNC_POL, 0, hsync active level
- VSYNC_POL, 0, vsync active level
- CNT_W, 10, x/y width
- FRAME_W, 16, frame counter width
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- enable  in  1  run/freeze
- p_tick  out  1  pixel strobe
- x  out  CNT_W  horizontal count
- y  out  CNT_W  vertical count
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  visible region
- line_start  out  1  one-clk new-line pulse
- frame_start  out  1  one-clk new-frame pulse
- frame_cnt  out  FRAME_W  frame number

Function
REQ-003 All state SHALL be clocked on clk only, with no derived clocks; p_tick is a clock enable.
REQ-004 Divider div SHALL count 0..CLK_DIV-1 while enable=1, wrap to 0, and hold while enable=0.
REQ-005 p_tick SHALL equal enable AND (div==CLK_DIV-1) combinationally; with CLK_DIV=1, p_tick=enable.
REQ-006 On a clk edge with p_tick=1, x SHALL increment, wrapping HT-1->0 where HT=H_DISPLAY+H_FRONT+H_SYNC+H_BACK.
REQ-007 On that wrap, y SHALL increment, wrapping VT-1->0 where VT=V_DISPLAY+V_FRONT+V_SYNC+V_BACK; otherwise y holds.
REQ-008 hsync, vsync, video_on, line_start and frame_start SHALL be registers loaded every clk from a decode of next-state x/y, so they are always aligned with x/y (zero relative latency).
REQ-009 hsync SHALL be at HSYNC_POL iff H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1, else ~HSYNC_POL.
REQ-010 vsync SHALL be at VSYNC_POL iff V_DISPLAY+V_FRONT <= y <= V_DISPLAY+V_FRONT+V_SYNC-1, else ~VSYNC_POL.
REQ-011 video_on SHALL be 1 iff x<H_DISPLAY and y<V_DISPLAY.
REQ-012 line_start SHALL be 1 for exactly the clk following an advance that makes x=0.
REQ-013 frame_start SHALL be 1 for exactly the clk following an advance that makes x=0 and y=0; it always coincides with line_start.
REQ-014 enable=0 SHALL freeze div, x, y, frame_cnt and all levels, and force p_tick, line_start and frame_start to 0 from the next clk.
REQ-015 Resuming enable SHALL continue from the frozen position with no lost or extra pixels.
REQ-016 Parameter sets with CLK_DIV=0, any zero-width region, or HT/VT above 2^CNT_W are unsupported; elaboration SHALL be rejected for them.

Reset
REQ-017 Asserting reset SHALL, immediately and regardless of clk: set div=0, x=0, y=0, frame_cnt=0, video_on=0, line_start=0, frame_start=0, hsync=~HSYNC_POL and vsync=~VSYNC_POL.
REQ-018 On the first clk after reset release, the status registers SHALL load the decode of (0,0) (video_on=1 with default parameters) and SHALL NOT pulse line_start or frame_start.
REQ-019 Reset mid-line or mid-frame SHALL abort the current frame with no residual sync pulse.

Configuration
REQ-020 With VGA_TIMING_FRAME_CNT_EN defined, frame_cnt SHALL increment modulo 2^FRAME_W on each advance that asserts frame_start.
REQ-021 With VGA_TIMING_FRAME_CNT_EN undefined, frame_cnt SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-022 Defaults, enable=1 -> p_tick every 2nd clk; line 1600 clk; hsync low for x=656..751 (96 ticks); video_on low from x=640.
REQ-023 Defaults, full frame -> vsync low exactly for y=490..491; frame_start every 840000 clk; with the macro, frame_cnt = 1, 2, 3.
REQ-024 H=4/1/2/1, V=3/1/1/1, CLK_DIV=1, HSYNC_POL=1 -> 8-clk lines; hsync high at x=5..6; 48-clk frames; line_start every 8 clk.
REQ-025 enable dropped at x=100, y=7 for 50 clk -> x/y/div frozen, p_tick=0; after resume, the next tick gives x=101.
REQ-026 Reset at x=700 (hsync active) -> hsync, vsync inactive and x=y=0 immediately; 1 clk after release video_on=1 with no frame_start.
REQ-027 FRAME_W=2 with the macro, 5 frames -> frame_cnt 1, 2, 3, 0, 1; without the macro -> frame_cnt stays 0.
